// File: rtl/qracc_seq_ctrl.sv
// QR accelerator sequencer: streams weight rows into SRAM, settles the array, then runs x batches with ADC sampling.
// Writes take one cycle after each handshake; a stalled stream or SRAM holds everything in place.
module qracc_seq_ctrl #(
    parameter int numRows      = 128,
    parameter int numCols      = 32,
    parameter int xBits        = 2,
    parameter int numCfgBits   = 8,
    parameter int settleCycles = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [numCfgBits-1:0]       n_rows_i,
    input  logic [numCfgBits-1:0]       n_batches_i,
    input  logic                        wt_valid_i,
    output logic                        wt_ready_o,
    input  logic [numCols-1:0]          wt_data_i,
    input  logic                        x_valid_i,
    output logic                        x_ready_o,
    input  logic [numRows*xBits-1:0]    x_data_i,
    output logic                        rq_valid_o,
    output logic                        rq_wr_o,
    input  logic                        rq_ready_i,
    output logic [$clog2(numRows)-1:0]  addr_o,
    output logic [numCols-1:0]          wr_data_o,
    output logic                        mac_en_o,
    output logic [numRows*xBits-1:0]    x_data_o,
    output logic                        sample_o,
    output logic                        busy_o,
    output logic                        done_o
);
    localparam int AW = $clog2(numRows);
    localparam int RW = $clog2(numRows + 1);
    localparam int CMAX = (settleCycles > xBits) ? settleCycles : xBits;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, MAC_WAIT, MAC_HOLD, DONE} state_e;

    state_e                     state_q, state_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [RW-1:0]              nrows_q, nrows_d;
    logic [numCfgBits-1:0]      nbat_q, nbat_d;
    logic [numCfgBits-1:0]      bcnt_q, bcnt_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       rqv_q, rqv_d;
    logic [numCols-1:0]         wdat_q, wdat_d;
    logic [numRows*xBits-1:0]   xdat_q, xdat_d;
    logic [RW-1:0]              nrows_clamp;

    // Row counts beyond the array size are capped so the address never wraps.
    always_comb begin
        if (int'(n_rows_i) > numRows) nrows_clamp = RW'(numRows);
        else                          nrows_clamp = RW'(n_rows_i);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        nrows_d    = nrows_q;
        nbat_d     = nbat_q;
        bcnt_d     = bcnt_q;
        cnt_d      = cnt_q;
        rqv_d      = rqv_q;
        wdat_d     = wdat_q;
        xdat_d     = xdat_q;
        wt_ready_o = 1'b0;
        x_ready_o  = 1'b0;
        mac_en_o   = 1'b0;
        sample_o   = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    nrows_d = nrows_clamp;
                    nbat_d  = n_batches_i;
                    addr_d  = '0;
                    bcnt_d  = '0;
                    cnt_d   = '0;
                    state_d = (nrows_clamp == '0) ? SETTLE : LOAD;
                end
            end
            LOAD: begin
                wt_ready_o = !rqv_q;
                if (wt_valid_i && !rqv_q) begin
                    wdat_d = wt_data_i;
                    rqv_d  = 1'b1;
                end
                if (rqv_q && rq_ready_i) begin
                    rqv_d = 1'b0;
                    if (RW'(addr_q) + 1'b1 == nrows_q) begin
                        addr_d  = '0;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            SETTLE: begin
                mac_en_o = 1'b1;
                if (cnt_q == CW'(settleCycles - 1)) begin
                    cnt_d   = '0;
                    state_d = (nbat_q == '0) ? DONE : MAC_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MAC_WAIT: begin
                mac_en_o  = 1'b1;
                x_ready_o = 1'b1;
                if (x_valid_i) begin
                    xdat_d  = x_data_i;
                    cnt_d   = '0;
                    state_d = MAC_HOLD;
                end
            end
            MAC_HOLD: begin
                mac_en_o = 1'b1;
                sample_o = 1'b1;
                if (cnt_q == CW'(xBits - 2)) begin
                    cnt_d   = '0;
                    bcnt_d  = bcnt_q + 1'b1;
                    state_d = (bcnt_q + 1'b1 == nbat_q) ? DONE : MAC_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            nrows_q <= '0;
            nbat_q  <= '0;
            bcnt_q  <= '0;
            cnt_q   <= '0;
            rqv_q   <= 1'b0;
            wdat_q  <= '0;
            xdat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            nrows_q <= nrows_d;
            nbat_q  <= nbat_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
            rqv_q   <= rqv_d;
            wdat_q  <= wdat_d;
            xdat_q  <= xdat_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign rq_valid_o = rqv_q;
    assign rq_wr_o    = rqv_q;
    assign addr_o     = addr_q;
    assign wr_data_o  = wdat_q;
    assign x_data_o   = xdat_q;

endmodule

// File: tb/tb_qracc_seq_ctrl.sv
// Scoreboard bench for qracc_seq_ctrl: accepted words/batches queue their expected SRAM writes and ADC samples,
// a negedge monitor pops and compares whenever the DUT presents a write or a sample.
module tb_qracc_seq_ctrl;
    localparam int NR = 128;
    localparam int NC = 32;
    localparam int XB = 3;
    localparam int ST = 5;
    localparam int AW = 7;
    localparam int XW = NR * XB;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [7:0]    n_rows_i, n_batches_i;
    logic          wt_valid_i, wt_ready_o;
    logic [NC-1:0] wt_data_i;
    logic          x_valid_i, x_ready_o;
    logic [XW-1:0] x_data_i;
    logic          rq_valid_o, rq_wr_o, rq_ready_i;
    logic [AW-1:0] addr_o;
    logic [NC-1:0] wr_data_o;
    logic          mac_en_o;
    logic [XW-1:0] x_data_o;
    logic          sample_o, busy_o, done_o;

    qracc_seq_ctrl #(.numRows(NR), .numCols(NC), .xBits(XB), .numCfgBits(8), .settleCycles(ST)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .n_rows_i(n_rows_i), .n_batches_i(n_batches_i),
        .wt_valid_i(wt_valid_i), .wt_ready_o(wt_ready_o), .wt_data_i(wt_data_i),
        .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_data_i(x_data_i),
        .rq_valid_o(rq_valid_o), .rq_wr_o(rq_wr_o), .rq_ready_i(rq_ready_i),
        .addr_o(addr_o), .wr_data_o(wr_data_o), .mac_en_o(mac_en_o), .x_data_o(x_data_o),
        .sample_o(sample_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [AW+NC-1:0] wq[$];
    logic [XW-1:0]    sq[$];
    int obs_writes, obs_samples, obs_done, settle_cnt;
    bit xr_seen;

    task automatic chk(input string nm, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: consumes expectations only when the DUT itself presents a write or a sample.
    logic          prev_hold = 1'b0;
    logic [AW-1:0] p_addr;
    logic [NC-1:0] p_data;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (rq_valid_o) begin
                if (prev_hold) begin
                    chk("hold_addr", addr_o, p_addr);
                    chk("hold_data", wr_data_o, p_data);
                end
                if (rq_ready_i) begin
                    if (wq.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL write_unexpected: got write at addr %0d, expected none", addr_o);
                    end else begin
                        logic [AW+NC-1:0] e;
                        e = wq.pop_front();
                        chk("wr_addr", addr_o, e[NC +: AW]);
                        chk("wr_data", wr_data_o, e[NC-1:0]);
                        chk("wr_flag", rq_wr_o, 1);
                    end
                    obs_writes++;
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                    p_addr = addr_o;
                    p_data = wr_data_o;
                end
            end else begin
                prev_hold = 1'b0;
            end
            if (sample_o) begin
                if (sq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL sample_unexpected: got sample, expected none");
                end else begin
                    chk("x_data", x_data_o, sq.pop_front());
                end
                chk("mac_en_at_sample", mac_en_o, 1);
                chk("x_ready_at_sample", x_ready_o, 0);
                obs_samples++;
            end
            if (!xr_seen) begin
                if (x_ready_o) xr_seen = 1'b1;
                else if (mac_en_o) settle_cnt++;
            end
            if (wt_ready_o) chk("mac_en_in_load", mac_en_o, 0);
            if (done_o) begin
                chk("busy_at_done", busy_o, 1);
                chk("mac_en_at_done", mac_en_o, 0);
                obs_done++;
            end
        end
    end

    task automatic idle_inputs();
        start_i = 0; wt_valid_i = 0; x_valid_i = 0; rq_ready_i = 0;
        wt_data_i = '0; x_data_i = '0; n_rows_i = '0; n_batches_i = '0;
    endtask

    task automatic reset_check(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_rq_valid"}, rq_valid_o, 0);
        chk({tag, "_mac_en"}, mac_en_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_sample"}, sample_o, 0);
        chk({tag, "_addr"}, addr_o, 0);
        chk({tag, "_wr_data"}, wr_data_o, 0);
        chk({tag, "_x_data"}, x_data_o, 0);
        idle_inputs();
        @(posedge clk); #1 rst = 1'b0;
        wq.delete(); sq.delete();
    endtask

    // abort: 0 = run to completion, 1 = reset at first sample, 2 = reset at first write request
    task automatic run(input int nr, input int nb, input int rmode, input int vpct, input bit poke, input int abort);
        int widx = 0;
        int stall = 0;
        bit got_done = 0;
        int exp_w;
        exp_w = (nr > NR) ? NR : nr;
        obs_writes = 0; obs_samples = 0; obs_done = 0; settle_cnt = 0; xr_seen = 0;
        for (int cyc = 0; cyc < 6000 && !got_done; cyc++) begin
            @(posedge clk); #1;
            start_i     = (cyc == 0) || (poke && busy_o && (cyc % 7 == 3));
            n_rows_i    = (cyc == 0) ? nr[7:0] : 8'($urandom);
            n_batches_i = (cyc == 0) ? nb[7:0] : 8'($urandom);
            wt_valid_i  = ($urandom_range(99) < vpct);
            wt_data_i   = $urandom;
            x_valid_i   = ($urandom_range(99) < vpct);
            for (int i = 0; i < XW / 32; i++) x_data_i[i*32 +: 32] = $urandom;
            case (rmode)
                0: rq_ready_i = 1'b1;
                1: begin
                    if (rq_valid_o && addr_o == 2 && stall < 3) begin
                        rq_ready_i = 1'b0;
                        stall++;
                    end else begin
                        rq_ready_i = 1'b1;
                    end
                end
                default: rq_ready_i = 1'($urandom_range(1));
            endcase
            @(negedge clk);
            if (wt_valid_i && wt_ready_o) begin
                wq.push_back({7'(widx), wt_data_i});
                widx++;
            end
            if (x_valid_i && x_ready_o)
                for (int k = 0; k < XB - 1; k++) sq.push_back(x_data_i);
            if ((abort == 1 && sample_o) || (abort == 2 && rq_valid_o)) begin
                reset_check(abort == 1 ? "rst_mac" : "rst_load");
                return;
            end
            if (done_o) got_done = 1;
        end
        idle_inputs();
        chk("done_seen", got_done, 1);
        repeat (2) @(negedge clk);
        chk("write_count", obs_writes, exp_w);
        chk("sample_count", obs_samples, nb * (XB - 1));
        chk("settle_cycles", settle_cnt, ST);
        chk("done_count", obs_done, 1);
        chk("wq_empty", wq.size(), 0);
        chk("sq_empty", sq.size(), 0);
        chk("busy_after", busy_o, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("reset_busy", busy_o, 0);
        chk("reset_rq_valid", rq_valid_o, 0);
        chk("reset_mac_en", mac_en_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_ready", {wt_ready_o, x_ready_o}, 0);
        chk("reset_x_data", x_data_o, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy_o, 0);

        run(4, 2, 0, 100, 0, 0);
        run(5, 2, 1, 100, 0, 0);
        run(0, 1, 0, 100, 0, 0);
        run(200, 1, 0, 100, 0, 0);
        run(6, 3, 2, 60, 1, 0);
        run(2, 3, 0, 100, 0, 1);
        run(3, 2, 0, 100, 0, 0);
        run(5, 1, 1, 100, 0, 2);
        run(3, 2, 2, 80, 0, 0);
        for (int r = 0; r < 8; r++) begin
            int nr, nb;
            nr = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(12));
            nb = $urandom_range(4);
            run(nr, nb, 2, $urandom_range(30, 100), r[0], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
